// File: rtl/regfile_param.sv
// Parameterised register file: NREAD combinational read ports with two-port write
// forwarding, PC alias on the top index, pending scoreboard and a post-reset clear sweep.

module regfile_param_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16
) (
    input  logic [ADDR_W-1:0] a,
    input  logic              ready,
    input  logic [DATA_W-1:0] r15,
    input  logic [DATA_W-1:0] rf_q,
    input  logic              pend_q,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd,
    output logic              haz
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS-1);

    logic hit_a, hit_b;
    assign hit_a = wa_en && (wa_addr == a);
    assign hit_b = wb_en && (wb_addr == a);

    // Port B forwards ahead of port A, matching the array's write priority.
    always_comb begin
        rd  = '0;
        haz = 1'b0;
        if (a == PC_IDX) begin
            rd = r15;
        end else if (ready && (a < PC_IDX)) begin
            if (hit_b)      rd = wb_data;
            else if (hit_a) rd = wa_data;
            else            rd = rf_q;
            haz = pend_q & ~(hit_a | hit_b);
        end
    end
endmodule

module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16,
    parameter int NREAD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we3,
    input  logic [ADDR_W-1:0]        wa3,
    input  logic [DATA_W-1:0]        wd3,
    input  logic                     we4,
    input  logic [ADDR_W-1:0]        wa4,
    input  logic [DATA_W-1:0]        wd4,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic [DATA_W-1:0]        r15,
    input  logic [NREAD*ADDR_W-1:0]  ra,
    output logic [NREAD*DATA_W-1:0]  rd,
    output logic [NREAD-1:0]         haz,
    output logic                     busy,
    output logic                     wconf
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS-1);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NREGS-2);

    typedef enum logic {CLEAR, READY} state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    state_t                  state, state_nx;
    logic                    ready;
    logic [ADDR_W-1:0]       ptr;
    logic [DATA_W-1:0]       rf [NREGS-1];
    logic [NREGS-1:0]        pend, pend_nx;
    wr_t                     wa, wb;
    logic [NREAD-1:0][DATA_W-1:0] rd_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == CLEAR && ptr == LAST) state_nx = READY;
    end

    always_comb begin
        busy  = (state == CLEAR);
        ready = (state == READY);
    end

    // Only accepted writes appear here: READY and a stored (non-PC, in-range) index.
    assign wa = '{en: ready && we3 && (wa3 < PC_IDX), addr: wa3, data: wd3};
    assign wb = '{en: ready && we4 && (wa4 < PC_IDX), addr: wa4, data: wd4};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= '0;
        else if (busy) ptr <= ptr + 1'b1;
    end

    // Storage is not reset; the sweep zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (busy) begin
            rf[ptr] <= '0;
        end else begin
            if (wa.en) rf[wa.addr] <= wa.data;
            if (wb.en) rf[wb.addr] <= wb.data;
        end
    end

    always_comb begin
        pend_nx = pend;
        if (wa.en) pend_nx[wa.addr] = 1'b0;
        if (wb.en) pend_nx[wb.addr] = 1'b0;
        if (ready && iss_en && (iss_dst < PC_IDX)) pend_nx[iss_dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= '0;
            wconf <= 1'b0;
        end else begin
            pend  <= pend_nx;
            wconf <= wa.en && wb.en && (wa.addr == wb.addr);
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] rf_q;
        logic              pend_q;
        assign a      = ra[i*ADDR_W +: ADDR_W];
        assign rf_q   = (a < PC_IDX) ? rf[a] : '0;
        assign pend_q = (a < PC_IDX) ? pend[a] : 1'b0;

        regfile_param_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rport (
            .a(a), .ready(ready), .r15(r15), .rf_q(rf_q), .pend_q(pend_q),
            .wa_en(wa.en), .wa_addr(wa.addr), .wa_data(wa.data),
            .wb_en(wb.en), .wb_addr(wb.addr), .wb_data(wb.data),
            .rd(rd_v[i]), .haz(haz[i])
        );
    end

    assign rd = rd_v;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed scenarios then random traffic, all checked
// against an array/counter model of the register file.

module tb_regfile_param;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    localparam int NREAD  = 2;

    logic clk = 1'b0;
    logic rst;
    logic we3, we4, iss_en;
    logic [ADDR_W-1:0] wa3, wa4, iss_dst;
    logic [DATA_W-1:0] wd3, wd4, r15;
    logic [NREAD-1:0][ADDR_W-1:0] ra_a;
    logic [NREAD-1:0][DATA_W-1:0] rd_a;
    logic [NREAD-1:0] haz;
    logic busy, wconf;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    int          clear_left;
    logic [31:0] mem [NREGS];
    bit          pend_m [NREGS];
    bit          wconf_m;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk(clk), .rst(rst),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .iss_en(iss_en), .iss_dst(iss_dst), .r15(r15),
        .ra(ra_a), .rd(rd_a), .haz(haz), .busy(busy), .wconf(wconf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit acc3();
        return clear_left == 0 && we3 && int'(wa3) != NREGS-1;
    endfunction

    function automatic bit acc4();
        return clear_left == 0 && we4 && int'(wa4) != NREGS-1;
    endfunction

    function automatic logic [31:0] exp_rd(input int a);
        if (a == NREGS-1)           return r15;
        if (clear_left > 0)         return 0;
        if (acc4() && int'(wa4) == a) return wd4;
        if (acc3() && int'(wa3) == a) return wd3;
        return mem[a];
    endfunction

    function automatic logic exp_haz(input int a);
        if (a == NREGS-1 || clear_left > 0) return 1'b0;
        if (acc4() && int'(wa4) == a) return 1'b0;
        if (acc3() && int'(wa3) == a) return 1'b0;
        return pend_m[a];
    endfunction

    task automatic mreset();
        clear_left = NREGS-1;
        wconf_m = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            mem[i] = 0;
            pend_m[i] = 1'b0;
        end
    endtask

    task automatic medge();
        bit a3, a4;
        a3 = acc3();
        a4 = acc4();
        if (clear_left > 0) begin
            clear_left--;
            wconf_m = 1'b0;
        end else begin
            wconf_m = a3 && a4 && wa3 == wa4;
            if (a3) pend_m[wa3] = 1'b0;
            if (a4) pend_m[wa4] = 1'b0;
            if (iss_en && int'(iss_dst) != NREGS-1) pend_m[iss_dst] = 1'b1;
            if (a3) mem[wa3] = wd3;
            if (a4) mem[wa4] = wd4;
        end
    endtask

    // Inputs are set at the negedge; combinational outputs are checked before the
    // rising edge and registered ones at the following negedge.
    task automatic cycle();
        if (rst) mreset();
        #1;
        for (int p = 0; p < NREAD; p++) begin
            chk($sformatf("rd%0d[ra=%0d]", p, ra_a[p]), rd_a[p], exp_rd(int'(ra_a[p])));
            chk($sformatf("haz%0d[ra=%0d]", p, ra_a[p]), {31'b0, haz[p]}, {31'b0, exp_haz(int'(ra_a[p]))});
        end
        @(posedge clk);
        if (rst) mreset(); else medge();
        @(negedge clk);
        chk("busy", {31'b0, busy}, {31'b0, clear_left > 0});
        chk("wconf", {31'b0, wconf}, {31'b0, wconf_m});
    endtask

    task automatic idle();
        we3 = 0; we4 = 0; iss_en = 0;
        wa3 = 0; wa4 = 0; iss_dst = 0;
        wd3 = 0; wd4 = 0;
    endtask

    task automatic sweep(input string tag);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cycle();
            cnt++;
        end
        chk(tag, cnt, NREGS-1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        r15 = 32'h108;
        ra_a[0] = 4'd2; ra_a[1] = 4'd15;
        cycle();
        cycle();

        // sweep with an ignored write to R2
        rst = 1'b0;
        we3 = 1; wa3 = 4'd2; wd3 = 32'hAAAA;
        sweep("busy_len");
        idle();
        for (int i = 0; i < NREGS-1; i++) begin
            ra_a[0] = 4'(i);
            ra_a[1] = 4'(NREGS-2-i);
            cycle();
        end

        // write + same-cycle forward, then read from array
        we3 = 1; wa3 = 4'd5; wd3 = 32'h1234; ra_a[0] = 4'd5;
        cycle();
        idle();
        cycle();

        // double write, port B wins
        we3 = 1; wa3 = 4'd7; wd3 = 32'h11;
        we4 = 1; wa4 = 4'd7; wd4 = 32'h22;
        ra_a[0] = 4'd7;
        cycle();
        idle();
        cycle();
        cycle();

        // PC alias and dropped write to index 15
        r15 = 32'h108; ra_a[1] = 4'd15; ra_a[0] = 4'd14;
        we3 = 1; wa3 = 4'd15; wd3 = 32'hDEAD;
        cycle();
        idle();
        cycle();

        // scoreboard
        iss_en = 1; iss_dst = 4'd3; ra_a[0] = 4'd3;
        cycle();
        idle();
        cycle();
        we4 = 1; wa4 = 4'd3; wd4 = 32'h55;
        cycle();
        idle();
        iss_en = 1; iss_dst = 4'd3; we3 = 1; wa3 = 4'd3; wd3 = 32'h66;
        cycle();
        idle();
        cycle();

        // mid-operation reset
        we3 = 1; wa3 = 4'd1; wd3 = 32'hFF; iss_en = 1; iss_dst = 4'd4;
        ra_a[0] = 4'd1; ra_a[1] = 4'd4;
        cycle();
        idle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sweep("busy_len_rst");
        cycle();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            we3     = $urandom_range(0, 1);
            we4     = $urandom_range(0, 2) == 0;
            iss_en  = $urandom_range(0, 2) == 0;
            wa3     = 4'($urandom_range(0, 15));
            wa4     = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
            iss_dst = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom_range(0, 15));
            wd3     = $urandom;
            wd4     = $urandom;
            r15     = $urandom;
            for (int p = 0; p < NREAD; p++) ra_a[p] = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file for the pipelined CPU core, the next generation of the three-port register file. It provides NREAD combinational read ports, two prioritised write ports (ALU writeback and load writeback) with same-cycle write-to-read forwarding, and the PC alias on the top index. It also has a per-register pending scoreboard for hazard detection and a post-reset clear sweep that zeroes the array without asynchronously resetting storage.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 4, register address width
- NREGS, 16, number of architectural indices; index NREGS-1 is the PC alias (not stored); 2 ≤ NREGS ≤ 2^ADDR_W
- NREAD, 2, number of read ports (1..4)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- we3  input  1  write enable, port A (ALU)
- wa3  input  ADDR_W  write address, port A
- wd3  input  DATA_W  write data, port A
- we4  input  1  write enable, port B (load)
- wa4  input  ADDR_W  write address, port B
- wd4  input  DATA_W  write data, port B
- iss_en  input  1  issue: mark iss_dst pending
- iss_dst  input  ADDR_W  destination of issued instruction
- r15  input  DATA_W  PC+8 value returned for index NREGS-1
- ra  input  NREAD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd  output  NREAD*DATA_W  packed read data, same packing
- haz  output  NREAD  per-port hazard: source register pending
- busy  output  1  clear sweep in progress
- wconf  output  1  registered flag: both write ports targeted the same address last cycle

## Operation
- FSM states: CLEAR, READY. rst forces CLEAR, sweep pointer ptr=0, all pending bits 0, wconf=0.
- CLEAR: each cycle rf[ptr]<=0, ptr++; after writing index NREGS-2 transition to READY. Duration is exactly NREGS-1 cycles after rst deasserts. busy=1 throughout CLEAR.
- In CLEAR: we3, we4, and iss_en are ignored. All rd ports return 0, except index NREGS-1, which returns r15. haz=0.
- READY: write port A stores wd3 at wa3 if we3; port B stores wd4 at wa4 if we4. Writes to index NREGS-1 or to an index ≥ NREGS are dropped.
- Same-address double write: port B wins. wconf is set to 1 for the following cycle, otherwise 0.
- Read port i, in priority order:
  - ra_i==NREGS-1 → r15.
  - ra_i ≥ NREGS → 0.
  - Port B writing ra_i this cycle → wd4.
  - Port A writing ra_i → wd3.
  - Otherwise rf[ra_i].
- Scoreboard pend[NREGS-1:0]:
  - iss_en sets pend[iss_dst].
  - Any accepted write clears pend[address].
  - Issue and write to the same address in one cycle: issue wins, pend stays 1.
  - Issue to NREGS-1 or to an out-of-range index is ignored.
- haz_i = pend[ra_i] & ~(same-cycle accepted write to ra_i), where ra_i is a valid stored index; otherwise 0.
- Reset mid-operation: immediate return to CLEAR; array contents are re-zeroed by the sweep; pending bits cleared asynchronously.

## Timing
- Reset values: busy=1, wconf=0, haz=0, rd=0 (r15 for PC index).
- Read and forward paths are combinational, with zero cycle latency.
- A write is visible from the array on the cycle after the edge; it is visible via forwarding in the same cycle.
- busy falls on the edge that writes index NREGS-2. The first accepted write is in the cycle where busy=0.
- pend updates on the rising edge; haz reflects pend plus same-cycle forwarding.
- wconf is registered, with 1-cycle latency.

## Test plan
- Reset sweep: assert rst, release → busy=1 for exactly 15 cycles (default parameters); we3=1 to R2 with 0xAAAA during the sweep is ignored; after busy=0, every rd for R0..R14 reads 0.
- Write/forward: we3=1, wa3=5, wd3=0x1234 with ra0=5 → rd0=0x1234 in the same cycle; next cycle we3=0 → rd0 still 0x1234.
- Port priority: we3 writes R7=0x11 and we4 writes R7=0x22 in the same cycle → rd for R7 returns 0x22 in the same cycle and afterwards; wconf=1 for one cycle, then 0.
- PC alias: r15=0x108 with ra1=15 → rd1=0x108; we3 to index 15 does not change a subsequent R14 read or any stored value.
- Scoreboard: iss_en, iss_dst=3; next cycle ra0=3 → haz0=1; then we4 to R3 with 0x55 → same cycle haz0=0 and rd0=0x55; a simultaneous issue and write to R3 → pend stays set, next cycle haz0=1.
- Mid-operation reset: load R1=0xFF and issue to R4, then assert rst → busy=1, haz=0, and after the sweep R1 reads 0 and R4 is not pending.
